// File: rtl/nt35510_axil_regs.sv
// rtl/nt35510_axil_regs.sv - AXI4-Lite register front end for the NT35510 LCD bus engine
//
// Four 32-bit read/write registers (CTRL, CMD, DATA, TIMING) selected by addr[3:2].
// Writes to CMD/DATA launch one valid/ready transaction towards the LCD engine and
// the B response waits until that transaction is accepted.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   s_axi_aw*/w*/b*       AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*          AXI4-Lite read address and data channels
//   ctrl_out              live copy of CTRL (bit0 panel reset, bit1 backlight)
//   lcd_valid/lcd_ready   LCD engine handshake
//   lcd_dc                0 = command (CMD register), 1 = data (DATA register)
//   lcd_word              LCD transaction payload

module nt35510_axil_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LCD_WORD_W         = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [31:0]                   ctrl_out,
    output logic                          lcd_valid,
    output logic                          lcd_dc,
    output logic [LCD_WORD_W-1:0]         lcd_word,
    input  logic                          lcd_ready
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_LCD  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [31:0] regs [4];
    logic [1:0]  w_state;
    logic [0:0]  r_state;
    logic [1:0]  w_idx;
    logic [1:0]  r_idx;
    logic        w_hs;
    logic        r_hs;
    logic [31:0] w_merged;

    // Address bits outside [3:2] are don't-care (aliasing / byte offset).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign w_idx = s_axi_awaddr[3:2];
    assign r_idx = s_axi_araddr[3:2];

    // AW and W are only taken together; readies are gated by reset so that every
    // ready output reads 0 while reset is held.
    assign w_hs = !reset && (w_state == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign r_hs = !reset && (r_state == R_IDLE) && s_axi_arvalid;

    assign s_axi_awready = w_hs;
    assign s_axi_wready  = w_hs;
    assign s_axi_arready = !reset && (r_state == R_IDLE);

    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rresp   = 2'b00;
    assign lcd_valid     = (w_state == W_LCD);
    assign ctrl_out      = regs[0];

    always_comb begin
        w_merged = regs[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (s_axi_wstrb[i]) begin
                w_merged[8*i +: 8] = s_axi_wdata[8*i +: 8];
            end
        end
    end

    // Write path. The LCD payload is latched from the merged value so it stays
    // stable for the whole time lcd_valid is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            w_state  <= W_IDLE;
            lcd_word <= '0;
            lcd_dc   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (w_hs) begin
                        regs[w_idx] <= w_merged;
                        if (w_idx == 2'd1 || w_idx == 2'd2) begin
                            lcd_word <= w_merged[LCD_WORD_W-1:0];
                            lcd_dc   <= (w_idx == 2'd2);
                            w_state  <= W_LCD;
                        end else begin
                            w_state <= W_RESP;
                        end
                    end
                end
                W_LCD: begin
                    if (lcd_ready) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path. A same-cycle write to the same register is seen only by later
    // reads, since regs[] updates on the same edge that captures rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= R_IDLE;
            s_axi_rdata <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (r_hs) begin
                        s_axi_rdata <= regs[r_idx];
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
